data_mem_mp: RTL and testbench
==============================

# data_mem_mp

Parametrised multi-port data memory for the Winograd datapath, successor to the fixed two-port 512-bit data memory. One scan write port fills the array from a self-incrementing write pointer, so the bench no longer drives scan addresses. NUM_RD independent read ports return data with a configurable fixed latency, and each port forwards its valid, address tag and range-error flag alongside the data. Reads are refused during loading. It sits between the tile controllers and the Winograd input-transform stage.

## Interface
- DATA_W, 512, word width in bits
- DEPTH, 128, number of words; legal range 2..256
- ADDR_W, 8, request address width; addresses >= DEPTH are out of range
- NUM_RD, 2, number of read ports; legal range 1..4
- OUT_REG, 1, 0 or 1: adds an output register stage
- clk  in  1  single clock for all logic, including scan
- reset  in  1  synchronous, active-high
- scan_mode  in  1  high = load mode, low = normal read mode
- scan_valid  in  1  write scan_in this cycle (ignored unless scan_mode = 1)
- scan_in  in  DATA_W  load data
- rd_valid_in  in  NUM_RD  per-port read request
- rd_addr_in  in  NUM_RD*ADDR_W  per-port address; port p uses bits [p*ADDR_W +: ADDR_W]
- rd_data_out  out  NUM_RD*DATA_W  per-port read data
- rd_addr_out  out  NUM_RD*ADDR_W  address tag aligned with the data
- rd_valid_out  out  NUM_RD  data valid
- rd_err_out  out  NUM_RD  out-of-range request, aligned with the data
- load_ptr  out  ADDR_W  next scan write address
- load_done  out  1  sticky: all DEPTH words have been written since the last load start
- busy  out  1  high while in LOAD

## Operation
- State machine (2 bits): IDLE, LOAD, READY.
- IDLE -> LOAD when scan_mode = 1. On entry, load_ptr and load_done clear to 0.
- In LOAD with scan_valid = 1:
  - mem[load_ptr] <= scan_in, then load_ptr increments.
  - When load_ptr = DEPTH-1 is written, load_ptr wraps to 0 and load_done sets.
  - Further scan_valid writes overwrite from address 0; load_done stays 1.
- LOAD -> READY when scan_mode = 0 and load_done = 1.
- LOAD -> IDLE when scan_mode = 0 and load_done = 0 (partial load).
  - Words already written are kept; load_ptr holds its value.
- READY -> LOAD when scan_mode = 1. This is a new load start, so the pointer and flag clear.
- busy = (state == LOAD).
- Read requests are accepted in IDLE and READY only.
  - In LOAD, rd_valid_in is dropped: no valid_out is produced for it.
- Accepted request on port p with address a < DEPTH: rd_data_out = mem[a], rd_err_out = 0.
- Accepted request with a >= DEPTH: rd_data_out = 0, rd_err_out = 1, rd_valid_out = 1. The array is not accessed.
- Any number of ports may read the same or different addresses in the same cycle. There are no conflicts and no stalls.
- When rd_valid_out = 0, rd_data_out holds its last value. rd_addr_out and rd_err_out follow the pipeline.
- The array is not reset. Reads of never-written words return X in simulation; this is legal.

## Timing
- Read latency LAT = 1 + OUT_REG cycles. A request at edge t produces rd_*_out valid after edge t+LAT.
  - Full throughput: one request per port per cycle.
- Scan write is visible to reads issued from the cycle after the write edge. Reads are blocked in LOAD anyway.
- The scan_mode transition and the state update happen on the same edge.
  - A read request in the cycle scan_mode rises is still accepted, because state is not yet LOAD.
  - A read request in the cycle scan_mode falls is dropped, because state is still LOAD.
- In-flight reads complete normally across a mode change.
- Reset (synchronous) clears:
  - state to IDLE
  - load_ptr, load_done, busy to 0
  - all rd_valid_out, rd_err_out, rd_addr_out, rd_data_out to 0
  - pipeline contents, so in-flight reads are discarded
- Reset mid-load: the array keeps the words already written, and load_done = 0.

## Test plan
- Full load: DEPTH=128, scan_mode = 1 with 128 consecutive scan_valid words (value = i*3) -> load_done = 1 after the 128th edge, load_ptr = 0. Drop scan_mode -> state READY. Read 0..127 on both ports -> data i*3 at LAT.
- Latency and throughput: OUT_REG = 0 and OUT_REG = 1 with back-to-back reads on all ports to addrs 5, 6, 7 -> valid_out exactly 1 or 2 cycles later, no bubbles, addr tags 5, 6, 7.
- Out of range: read 200 on port 0 and 10 on port 1 in the same cycle -> port 0 err = 1, data = 0, valid = 1; port 1 data = mem[10], err = 0.
- Blocked reads: issue reads while busy = 1 -> no rd_valid_out. The request in the scan_mode-rise cycle is served; the request in the scan_mode-fall cycle is dropped.
- Partial load and reload: write 40 words, drop scan_mode -> state IDLE, load_done = 0, load_ptr = 40, reads of 0..39 correct. Re-raise scan_mode -> load_ptr = 0.
- Reset mid-load: reset at word 60 -> all outputs 0, state IDLE, in-flight valids gone. After reset, addresses 0..59 still hold the loaded data.

Source files
------------

// File: rtl/data_mem_mp_if.sv
// data_mem_mp_if: scan-load and multi-port read bundle for data_mem_mp
interface data_mem_mp_if #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 8,
  parameter int NUM_RD = 2
);
  logic                     scan_mode;
  logic                     scan_valid;
  logic [DATA_W-1:0]        scan_in;
  logic [NUM_RD-1:0]        rd_valid_in;
  logic [NUM_RD*ADDR_W-1:0] rd_addr_in;
  logic [NUM_RD*DATA_W-1:0] rd_data_out;
  logic [NUM_RD*ADDR_W-1:0] rd_addr_out;
  logic [NUM_RD-1:0]        rd_valid_out;
  logic [NUM_RD-1:0]        rd_err_out;
  logic [ADDR_W-1:0]        load_ptr;
  logic                     load_done;
  logic                     busy;
  modport master (
    output scan_mode, scan_valid, scan_in, rd_valid_in, rd_addr_in,
    input  rd_data_out, rd_addr_out, rd_valid_out, rd_err_out, load_ptr, load_done, busy
  );
  modport slave (
    input  scan_mode, scan_valid, scan_in, rd_valid_in, rd_addr_in,
    output rd_data_out, rd_addr_out, rd_valid_out, rd_err_out, load_ptr, load_done, busy
  );
endinterface

// File: rtl/data_mem_mp.sv
// data_mem_mp: scan-loaded data memory with NUM_RD fixed-latency read ports
module data_mem_mp #(
  parameter int DATA_W  = 512,
  parameter int DEPTH   = 128,
  parameter int ADDR_W  = 8,
  parameter int NUM_RD  = 2,
  parameter int OUT_REG = 1
) (
  input logic         clk,
  input logic         reset,
  data_mem_mp_if.slave bus
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] ptr;
  logic done, start, wr, last;
  logic [NUM_RD-1:0] acc, oor, v1, e1;
  logic [NUM_RD-1:0][ADDR_W-1:0] ai, a1;
  logic [NUM_RD-1:0][DATA_W-1:0] d1;
  always_comb begin
    state_nx = state;
    state_nx = bus.scan_mode ? LOAD : state == LOAD ? (done ? READY : IDLE) : state == READY ? READY : IDLE;
  end
  assign start = bus.scan_mode && state != LOAD;
  assign wr    = !reset && state == LOAD && bus.scan_mode && bus.scan_valid;
  assign last  = ptr == ADDR_W'(DEPTH - 1);
  assign ai    = bus.rd_addr_in;
  assign acc   = bus.rd_valid_in & {NUM_RD{state != LOAD}};
  always_comb begin
    oor = '0;
    for (int p = 0; p < NUM_RD; p++) oor[p] = {1'b0, ai[p]} >= (ADDR_W+1)'(DEPTH);
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      if (start) begin
        ptr  <= '0;
        done <= 1'b0;
      end else if (wr) begin
        ptr  <= last ? '0 : ptr + ADDR_W'(1);
        done <= done | last;
      end
    end
  // array has no reset so a mid-load reset keeps already written words
  always_ff @(posedge clk)
    if (wr) mem[ptr[IW-1:0]] <= bus.scan_in;
  always_ff @(posedge clk)
    if (reset) begin
      v1 <= '0;
      e1 <= '0;
      a1 <= '0;
      d1 <= '0;
    end else begin
      v1 <= acc;
      e1 <= acc & oor;
      a1 <= ai;
      for (int p = 0; p < NUM_RD; p++)
        if (acc[p]) d1[p] <= oor[p] ? '0 : mem[ai[p][IW-1:0]];
    end
  assign bus.load_ptr  = ptr;
  assign bus.load_done = done;
  assign bus.busy      = state == LOAD;
  if (OUT_REG != 0) begin : g_reg
    logic [NUM_RD-1:0] v2, e2;
    logic [NUM_RD-1:0][ADDR_W-1:0] a2;
    logic [NUM_RD-1:0][DATA_W-1:0] d2;
    always_ff @(posedge clk)
      if (reset) begin
        v2 <= '0;
        e2 <= '0;
        a2 <= '0;
        d2 <= '0;
      end else begin
        v2 <= v1;
        e2 <= e1;
        a2 <= a1;
        d2 <= d1;
      end
    assign bus.rd_valid_out = v2;
    assign bus.rd_err_out   = e2;
    assign bus.rd_addr_out  = a2;
    assign bus.rd_data_out  = d2;
  end else begin : g_direct
    assign bus.rd_valid_out = v1;
    assign bus.rd_err_out   = e1;
    assign bus.rd_addr_out  = a1;
    assign bus.rd_data_out  = d1;
  end
endmodule

// File: tb/tb_data_mem_mp.sv
// tb_data_mem_mp: checks OUT_REG=0 and OUT_REG=1 instances side by side against a reference model
module tb_data_mem_mp;
  localparam int DW = 512, DEPTH = 128, AW = 8, NR = 2;
  localparam int IDLE = 0, LOAD = 1, READY = 2;
  typedef struct {
    logic [NR-1:0] v, e, k;
    logic z;
    logic [NR-1:0][AW-1:0] a;
    logic [NR-1:0][DW-1:0] d;
  } ent_t;
  typedef struct {
    int a0, a1;
    logic [DW-1:0] d0, d1;
    logic e0, e1;
  } vec_t;
  logic clk = 0;
  logic reset = 1;
  data_mem_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) b0 ();
  data_mem_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) b1 ();
  assign b0.scan_mode   = b1.scan_mode;
  assign b0.scan_valid  = b1.scan_valid;
  assign b0.scan_in     = b1.scan_in;
  assign b0.rd_valid_in = b1.rd_valid_in;
  assign b0.rd_addr_in  = b1.rd_addr_in;
  data_mem_mp #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .NUM_RD(NR), .OUT_REG(0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  data_mem_mp #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .NUM_RD(NR), .OUT_REG(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  always #5 clk = ~clk;
  int total = 0, bad = 0, cyc = 0, mode = IDLE, ptr = 0;
  bit done = 0;
  logic [DW-1:0] rmem [DEPTH];
  bit known [DEPTH];
  logic [NR-1:0][DW-1:0] hold_d;
  logic [NR-1:0] hold_k;
  ent_t ring [4];
  vec_t tbl [8];
  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  task automatic chk(string n, logic [DW-1:0] act, logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, act, exp);
    end
  endtask
  task automatic cmp(string n, logic [NR-1:0] v, logic [NR-1:0] e, logic [NR*AW-1:0] a,
                     logic [NR*DW-1:0] d, ent_t en);
    for (int p = 0; p < NR; p++) begin
      chk($sformatf("%s_valid%0d c%0d", n, p, cyc), DW'(v[p]), DW'(en.v[p]));
      if (en.v[p] || en.z) begin
        chk($sformatf("%s_err%0d c%0d", n, p, cyc), DW'(e[p]), DW'(en.e[p]));
        chk($sformatf("%s_tag%0d c%0d", n, p, cyc), DW'(a[p*AW +: AW]), DW'(en.a[p]));
      end
      if (en.k[p]) chk($sformatf("%s_data%0d c%0d", n, p, cyc), d[p*DW +: DW], en.d[p]);
    end
  endtask
  // one clock: predict this edge's read results, advance, update model, compare both latencies
  task automatic step();
    ent_t en;
    en.v = '0; en.e = '0; en.k = '1; en.z = reset; en.a = '0; en.d = '0;
    if (reset) begin
      hold_d = '0;
      hold_k = '1;
      ring[(cyc + 3) % 4] = en;
    end else begin
      for (int p = 0; p < NR; p++) begin
        int a;
        a = int'(b1.rd_addr_in[p*AW +: AW]);
        if (b1.rd_valid_in[p] && mode != LOAD) begin
          en.v[p] = 1'b1;
          en.a[p] = AW'(a);
          en.e[p] = a >= DEPTH;
          hold_d[p] = a >= DEPTH ? '0 : rmem[a];
          hold_k[p] = a >= DEPTH || known[a];
        end
        en.d[p] = hold_d[p];
        en.k[p] = hold_k[p];
      end
    end
    ring[cyc % 4] = en;
    @(posedge clk);
    if (reset) begin
      mode = IDLE; ptr = 0; done = 0;
    end else if (mode != LOAD) begin
      if (b1.scan_mode) begin mode = LOAD; ptr = 0; done = 0; end
    end else if (!b1.scan_mode) begin
      mode = done ? READY : IDLE;
    end else if (b1.scan_valid) begin
      rmem[ptr] = b1.scan_in;
      known[ptr] = 1;
      if (ptr == DEPTH - 1) done = 1;
      ptr = (ptr + 1) % DEPTH;
    end
    #1;
    cmp("lat1", b0.rd_valid_out, b0.rd_err_out, b0.rd_addr_out, b0.rd_data_out, ring[cyc % 4]);
    cmp("lat2", b1.rd_valid_out, b1.rd_err_out, b1.rd_addr_out, b1.rd_data_out, ring[(cyc + 3) % 4]);
    chk($sformatf("load_ptr c%0d", cyc), DW'(b1.load_ptr), DW'(ptr));
    chk($sformatf("load_done c%0d", cyc), DW'(b1.load_done), DW'(done));
    chk($sformatf("busy c%0d", cyc), DW'(b1.busy), DW'(mode == LOAD));
    chk($sformatf("busy0 c%0d", cyc), DW'(b0.busy), DW'(mode == LOAD));
    cyc++;
  endtask
  initial begin
    tbl[0] = '{5, 6, 15, 18, 0, 0};
    tbl[1] = '{7, 127, 21, 381, 0, 0};
    tbl[2] = '{200, 10, 0, 30, 1, 0};
    tbl[3] = '{10, 200, 30, 0, 0, 1};
    tbl[4] = '{128, 0, 0, 0, 1, 0};
    tbl[5] = '{255, 127, 0, 381, 1, 0};
    tbl[6] = '{64, 64, 192, 192, 0, 0};
    tbl[7] = '{0, 1, 0, 3, 0, 0};
    b1.scan_mode = 0; b1.scan_valid = 0; b1.scan_in = '0; b1.rd_valid_in = '0; b1.rd_addr_in = '0;
    step();
    step();
    chk("rst_valid", DW'(b1.rd_valid_out), 0);
    chk("rst_data", b1.rd_data_out[0 +: DW], 0);
    chk("rst_ptr", DW'(b1.load_ptr), 0);
    reset = 0;
    step();
    b1.scan_mode = 1; b1.rd_valid_in = 2'b01; b1.rd_addr_in = {8'd0, 8'd3};
    step();
    chk("rise_served", DW'(b0.rd_valid_out), 1);
    for (int i = 0; i < DEPTH; i++) begin
      b1.scan_valid = 1; b1.scan_in = DW'(i * 3); b1.rd_valid_in = 2'b11;
      step();
      chk("load_blocked", DW'(b0.rd_valid_out), 0);
    end
    b1.scan_valid = 0;
    chk("full_done", DW'(b1.load_done), 1);
    chk("full_ptr", DW'(b1.load_ptr), 0);
    b1.scan_mode = 0;
    step();
    chk("fall_drop", DW'(b0.rd_valid_out), 0);
    b1.rd_valid_in = 0;
    step();
    chk("fall_drop2", DW'(b1.rd_valid_out), 0);
    for (int i = 0; i < DEPTH; i++) begin
      b1.rd_valid_in = 2'b11; b1.rd_addr_in = {AW'(DEPTH - 1 - i), AW'(i)};
      step();
    end
    for (int a = 5; a <= 7; a++) begin
      b1.rd_addr_in = {AW'(a), AW'(a)};
      step();
    end
    chk("bb_tag_lat1", DW'(b0.rd_addr_out[0 +: AW]), 7);
    chk("bb_tag_lat2", DW'(b1.rd_addr_out[0 +: AW]), 6);
    b1.rd_valid_in = 0;
    step();
    chk("bb_last_valid", DW'(b1.rd_valid_out), 3);
    chk("bb_last_tag", DW'(b1.rd_addr_out[AW +: AW]), 7);
    chk("bb_last_data", b1.rd_data_out[DW +: DW], 21);
    chk("bb_lat1_idle", DW'(b0.rd_valid_out), 0);
    foreach (tbl[i]) begin
      b1.rd_valid_in = 2'b11; b1.rd_addr_in = {AW'(tbl[i].a1), AW'(tbl[i].a0)};
      step();
      b1.rd_valid_in = 0;
      step();
      chk($sformatf("tbl%0d_v", i), DW'(b1.rd_valid_out), 3);
      chk($sformatf("tbl%0d_d0", i), b1.rd_data_out[0 +: DW], tbl[i].d0);
      chk($sformatf("tbl%0d_d1", i), b1.rd_data_out[DW +: DW], tbl[i].d1);
      chk($sformatf("tbl%0d_e0", i), DW'(b1.rd_err_out[0]), DW'(tbl[i].e0));
      chk($sformatf("tbl%0d_e1", i), DW'(b1.rd_err_out[1]), DW'(tbl[i].e1));
    end
    b1.rd_valid_in = 2'b11; b1.rd_addr_in = {8'd20, 8'd10};
    step();
    b1.rd_valid_in = 0; reset = 1;
    step();
    chk("inflight_gone", DW'(b1.rd_valid_out), 0);
    reset = 0;
    step();
    b1.scan_mode = 1;
    step();
    for (int i = 0; i < 40; i++) begin
      b1.scan_valid = 1; b1.scan_in = rnd();
      step();
    end
    b1.scan_valid = 0; b1.scan_mode = 0;
    step();
    chk("part_ptr", DW'(b1.load_ptr), 40);
    chk("part_done", DW'(b1.load_done), 0);
    chk("part_busy", DW'(b1.busy), 0);
    for (int i = 0; i < 40; i++) begin
      b1.rd_valid_in = 2'b11; b1.rd_addr_in = {AW'(39 - i), AW'(i)};
      step();
    end
    b1.rd_valid_in = 0; b1.scan_mode = 1;
    step();
    chk("reload_ptr", DW'(b1.load_ptr), 0);
    chk("reload_busy", DW'(b1.busy), 1);
    for (int i = 0; i < 60; i++) begin
      b1.scan_valid = 1; b1.scan_in = rnd();
      step();
    end
    b1.scan_valid = 0; reset = 1;
    step();
    chk("rml_busy", DW'(b1.busy), 0);
    chk("rml_done", DW'(b1.load_done), 0);
    chk("rml_ptr", DW'(b1.load_ptr), 0);
    chk("rml_err", DW'(b1.rd_err_out), 0);
    chk("rml_tag", DW'(b1.rd_addr_out), 0);
    reset = 0; b1.scan_mode = 0;
    step();
    for (int i = 0; i < 60; i++) begin
      b1.rd_valid_in = 2'b11; b1.rd_addr_in = {AW'(59 - i), AW'(i)};
      step();
    end
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) b1.scan_mode = ~b1.scan_mode;
      b1.scan_valid = 1'($urandom);
      b1.scan_in = rnd();
      b1.rd_valid_in = 2'($urandom);
      b1.rd_addr_in = {AW'($urandom_range(0, 159)), AW'($urandom_range(0, 159))};
      reset = $urandom_range(0, 149) == 0;
      step();
    end
    reset = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
